// File: rtl/riscv_mcyc_ctrl.sv
// Multi-cycle RV32I control FSM: sequences PC/IR/ALUOut datapath one instruction at a time.
// Optional MCYC_MEM_WAIT_EN: FETCH, MEM_RD and MEM_WR stall until mem_rdy.
module riscv_mcyc_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_rdy,
    output logic        pc_we,
    output logic        ir_we,
    output logic        reg_we,
    output logic        mem_we,
    output logic        adr_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  res_src,
    output logic [2:0]  imm_src,
    output logic [3:0]  alu_ctrl,
    output logic [3:0]  state,
    output logic        illegal
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEM_ADR = 4'd2, MEM_RD = 4'd3,
        MEM_WB = 4'd4, MEM_WR = 4'd5, EXEC_R = 4'd6, EXEC_I = 4'd7,
        ALU_WB = 4'd8, BRANCH = 4'd9, JAL = 4'd10, JALR = 4'd11,
        LUI = 4'd12, TRAP = 4'd15
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                           ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLL = 4'd6, ALU_SRL = 4'd7,
                           ALU_SRA = 4'd8;

    state_t cur, nxt;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7b5, is_r, rdy;
    logic [3:0] alu_dec;
    logic       pc_we_c, ir_we_c, reg_we_c, mem_we_c;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign f7b5   = instr[30];
    assign is_r   = (opcode == 7'b0110011);

`ifdef MCYC_MEM_WAIT_EN
    assign rdy = mem_rdy;
`else
    logic unused_mem_rdy;
    assign unused_mem_rdy = mem_rdy;
    assign rdy = 1'b1;
`endif

    logic unused_instr;
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

    always_ff @(posedge clk) begin
        if (rst) cur <= FETCH;
        else     cur <= nxt;
    end

    // funct3 011 has no ALU meaning here and routes to TRAP in the EXEC states
    always_comb begin
        alu_dec = ALU_ADD;
        case (funct3)
            3'b000:  alu_dec = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_dec = ALU_SLL;
            3'b010:  alu_dec = ALU_SLT;
            3'b100:  alu_dec = ALU_XOR;
            3'b101:  alu_dec = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_dec = ALU_OR;
            3'b111:  alu_dec = ALU_AND;
            default: alu_dec = ALU_ADD;
        endcase
    end

    always_comb begin
        nxt       = cur;
        pc_we_c   = 1'b0;
        ir_we_c   = 1'b0;
        reg_we_c  = 1'b0;
        mem_we_c  = 1'b0;
        adr_src   = 1'b0;
        alu_src_a = 2'b00;
        alu_src_b = 2'b00;
        res_src   = 2'b00;
        imm_src   = 3'd0;
        alu_ctrl  = ALU_ADD;
        case (cur)
            FETCH: begin
                alu_src_b = 2'b10;
                res_src   = 2'b10;
                ir_we_c   = rdy;
                pc_we_c   = rdy;
                if (rdy) nxt = DECODE;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = (opcode == 7'b1101111) ? 3'd3 : 3'd2;
                case (opcode)
                    7'b0000011, 7'b0100011: nxt = MEM_ADR;
                    7'b0110011:             nxt = EXEC_R;
                    7'b0010011:             nxt = EXEC_I;
                    7'b1100011:             nxt = BRANCH;
                    7'b1101111:             nxt = JAL;
                    7'b1100111:             nxt = JALR;
                    7'b0110111:             nxt = LUI;
                    default:                nxt = TRAP;
                endcase
            end
            MEM_ADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = (opcode == 7'b0100011) ? 3'd1 : 3'd0;
                if (funct3 != 3'b010)          nxt = TRAP;
                else if (opcode == 7'b0100011) nxt = MEM_WR;
                else                           nxt = MEM_RD;
            end
            MEM_RD: begin
                adr_src = 1'b1;
                if (rdy) nxt = MEM_WB;
            end
            MEM_WB: begin
                res_src  = 2'b01;
                reg_we_c = 1'b1;
                nxt      = FETCH;
            end
            MEM_WR: begin
                adr_src  = 1'b1;
                mem_we_c = 1'b1;
                if (rdy) nxt = FETCH;
            end
            EXEC_R, EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = (cur == EXEC_I) ? 2'b01 : 2'b00;
                alu_ctrl  = alu_dec;
                nxt       = (funct3 == 3'b011) ? TRAP : ALU_WB;
            end
            ALU_WB: begin
                reg_we_c = 1'b1;
                nxt      = FETCH;
            end
            BRANCH: begin
                alu_src_a = 2'b10;
                alu_ctrl  = ALU_SUB;
                case (funct3)
                    3'b000:  begin pc_we_c = zero;  nxt = FETCH; end
                    3'b001:  begin pc_we_c = ~zero; nxt = FETCH; end
                    default: nxt = TRAP;
                endcase
            end
            JALR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                nxt       = JAL;
            end
            // PC takes the target from ALUOut while the ALU forms OldPC + 4 for rd
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_we_c   = 1'b1;
                nxt       = ALU_WB;
            end
            LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                imm_src   = 3'd4;
                nxt       = ALU_WB;
            end
            TRAP:    nxt = TRAP;
            default: nxt = TRAP;
        endcase
    end

    assign pc_we   = pc_we_c  & ~rst;
    assign ir_we   = ir_we_c  & ~rst;
    assign reg_we  = reg_we_c & ~rst;
    assign mem_we  = mem_we_c & ~rst;
    assign state   = cur;
    assign illegal = (cur == TRAP);
endmodule

// File: tb/tb_riscv_mcyc_ctrl.sv
// Scoreboard bench for riscv_mcyc_ctrl: per-cycle expected outputs queued per instruction.
module tb_riscv_mcyc_ctrl;
    logic        clk = 1'b0;
    logic        rst, zero, mem_rdy;
    logic [31:0] instr;
    logic        pc_we, ir_we, reg_we, mem_we, adr_src, illegal;
    logic [1:0]  alu_src_a, alu_src_b, res_src;
    logic [2:0]  imm_src;
    logic [3:0]  alu_ctrl, state;

    riscv_mcyc_ctrl dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_rdy(mem_rdy),
        .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we), .mem_we(mem_we),
        .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .res_src(res_src), .imm_src(imm_src), .alu_ctrl(alu_ctrl),
        .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        logic [3:0] en;   // {pc, ir, reg, mem}
        logic       adr;
        logic [1:0] a, b, rs;
        logic [2:0] imm;
        logic [3:0] alu;
        logic       ill;
        logic       rdy, z;  // stimulus applied during this cycle
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic push(input logic [3:0] st, input logic [3:0] en, input logic adr,
                        input logic [1:0] a, input logic [1:0] b, input logic [1:0] rs,
                        input logic [2:0] imm, input logic [3:0] alu, input logic ill,
                        input logic rdy = 1'b1, input logic z = 1'b0);
        exp_t e;
        e.st = st; e.en = en; e.adr = adr; e.a = a; e.b = b; e.rs = rs;
        e.imm = imm; e.alu = alu; e.ill = ill; e.rdy = rdy; e.z = z;
        q.push_back(e);
    endtask

    task automatic p_fetch(input logic rdy = 1'b1);
        push(4'd0, {rdy, rdy, 2'b00}, 0, 2'b00, 2'b10, 2'b10, 3'd0, 4'd0, 0, rdy);
    endtask
    task automatic p_dec(input logic [2:0] imm = 3'd2);
        push(4'd1, 4'b0000, 0, 2'b01, 2'b01, 2'b00, imm, 4'd0, 0);
    endtask
    task automatic p_alu_wb();
        push(4'd8, 4'b0010, 0, 2'b00, 2'b00, 2'b00, 3'd0, 4'd0, 0);
    endtask

    // Pops one expected record per clock and compares every output in that cycle.
    task automatic drain();
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            mem_rdy = e.rdy;
            zero    = e.z;
            #1;
            chk("state", {28'd0, state}, {28'd0, e.st});
            chk("enables", {28'd0, pc_we, ir_we, reg_we, mem_we}, {28'd0, e.en});
            chk("adr_src", {31'd0, adr_src}, {31'd0, e.adr});
            chk("alu_src_a", {30'd0, alu_src_a}, {30'd0, e.a});
            chk("alu_src_b", {30'd0, alu_src_b}, {30'd0, e.b});
            chk("res_src", {30'd0, res_src}, {30'd0, e.rs});
            chk("imm_src", {29'd0, imm_src}, {29'd0, e.imm});
            chk("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, e.alu});
            chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; zero = 1'b0; mem_rdy = 1'b1; instr = 32'h0000_0013;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", {28'd0, state}, 32'd0);
        chk("rst_enables", {28'd0, pc_we, ir_we, reg_we, mem_we}, 32'd0);
        rst = 1'b0;

        // add x3,x1,x2
        instr = 32'h0020_81b3;
        p_fetch(); p_dec();
        push(4'd6, 4'b0000, 0, 2'b10, 2'b00, 2'b00, 3'd0, 4'd0, 0);
        p_alu_wb();
        drain();

        // sub x3,x1,x2
        instr = 32'h4020_81b3;
        p_fetch(); p_dec();
        push(4'd6, 4'b0000, 0, 2'b10, 2'b00, 2'b00, 3'd0, 4'd1, 0);
        p_alu_wb();
        drain();

        // jalr ra,x3,4
        instr = 32'h0041_80e7;
        p_fetch(); p_dec();
        push(4'd11, 4'b0000, 0, 2'b10, 2'b01, 2'b00, 3'd0, 4'd0, 0);
        push(4'd10, 4'b1000, 0, 2'b01, 2'b10, 2'b00, 3'd0, 4'd0, 0);
        p_alu_wb();
        drain();

        // beq taken / not taken, bne not taken / taken
        instr = 32'h0020_8463;
        p_fetch(); p_dec();
        push(4'd9, 4'b1000, 0, 2'b10, 2'b00, 2'b00, 3'd0, 4'd1, 0, 1'b1, 1'b1);
        p_fetch(); p_dec();
        push(4'd9, 4'b0000, 0, 2'b10, 2'b00, 2'b00, 3'd0, 4'd1, 0, 1'b1, 1'b0);
        drain();
        instr = 32'h0020_9463;
        p_fetch(); p_dec();
        push(4'd9, 4'b0000, 0, 2'b10, 2'b00, 2'b00, 3'd0, 4'd1, 0, 1'b1, 1'b1);
        p_fetch(); p_dec();
        push(4'd9, 4'b1000, 0, 2'b10, 2'b00, 2'b00, 3'd0, 4'd1, 0, 1'b1, 1'b0);
        drain();

        // addi x3,x1,5 and srai x3,x1,2
        instr = 32'h0050_8193;
        p_fetch(); p_dec();
        push(4'd7, 4'b0000, 0, 2'b10, 2'b01, 2'b00, 3'd0, 4'd0, 0);
        p_alu_wb();
        drain();
        instr = 32'h4020_d193;
        p_fetch(); p_dec();
        push(4'd7, 4'b0000, 0, 2'b10, 2'b01, 2'b00, 3'd0, 4'd8, 0);
        p_alu_wb();
        drain();

        // lui x3,0x12345
        instr = 32'h1234_51b7;
        p_fetch(); p_dec();
        push(4'd12, 4'b0000, 0, 2'b11, 2'b01, 2'b00, 3'd4, 4'd0, 0);
        p_alu_wb();
        drain();

        // lw x3,0(x1): with the wait option, FETCH and MEM_RD stall on mem_rdy
        instr = 32'h0000_a183;
`ifdef MCYC_MEM_WAIT_EN
        p_fetch(1'b0);
`endif
        p_fetch(); p_dec();
        push(4'd2, 4'b0000, 0, 2'b10, 2'b01, 2'b00, 3'd0, 4'd0, 0);
`ifdef MCYC_MEM_WAIT_EN
        push(4'd3, 4'b0000, 1, 2'b00, 2'b00, 2'b00, 3'd0, 4'd0, 0, 1'b0);
        push(4'd3, 4'b0000, 1, 2'b00, 2'b00, 2'b00, 3'd0, 4'd0, 0, 1'b0);
`endif
        push(4'd3, 4'b0000, 1, 2'b00, 2'b00, 2'b00, 3'd0, 4'd0, 0);
        push(4'd4, 4'b0010, 0, 2'b00, 2'b00, 2'b01, 3'd0, 4'd0, 0);
        drain();

        // sw x3,0(x1)
        instr = 32'h0030_a023;
        p_fetch(); p_dec();
        push(4'd2, 4'b0000, 0, 2'b10, 2'b01, 2'b00, 3'd1, 4'd0, 0);
`ifdef MCYC_MEM_WAIT_EN
        push(4'd5, 4'b0001, 1, 2'b00, 2'b00, 2'b00, 3'd0, 4'd0, 0, 1'b0);
`endif
        push(4'd5, 4'b0001, 1, 2'b00, 2'b00, 2'b00, 3'd0, 4'd0, 0);
        drain();

        // all-zero word traps and sticks until reset
        instr = 32'h0000_0000;
        p_fetch(); p_dec();
        for (int i = 0; i < 10; i++)
            push(4'd15, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 3'd0, 4'd0, 1);
        drain();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; #1;
        chk("trap_rst_state", {28'd0, state}, 32'd0);
        chk("trap_rst_illegal", {31'd0, illegal}, 32'd0);

        // reset landing in MEM_WR must suppress the store
        instr = 32'h0030_a023;
        mem_rdy = 1'b1;
        p_fetch(); p_dec();
        push(4'd2, 4'b0000, 0, 2'b10, 2'b01, 2'b00, 3'd1, 4'd0, 0);
        drain();
        rst = 1'b1; #1;
        chk("memwr_rst_state", {28'd0, state}, 32'd5);
        chk("memwr_rst_mem_we", {31'd0, mem_we}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; #1;
        chk("memwr_after_state", {28'd0, state}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/riscv_mcyc_ctrl.md
# riscv_mcyc_ctrl

Multi-cycle control FSM for the RV32I core. It sequences a shared-ALU, shared-memory datapath (PC, OldPC, IR, ALUOut and data registers) one instruction at a time. Each state drives the datapath mux selects and write enables from the opcode, funct3 and funct7 held in IR. The block replaces the single-cycle combinational control path and supports lw, sw, R-type, I-type ALU, beq/bne, jal, jalr and lui.

## Interface
Parameters:
- none.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  IR contents.
- zero  in  1  ALU zero flag, combinational from the current cycle.
- mem_rdy  in  1  memory access complete; used only with MCYC_MEM_WAIT_EN.
- pc_we, ir_we, reg_we, mem_we  out  1 each  write enables.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1, 11 = constant 0.
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4.
- res_src  out  2  00 = ALUOut, 01 = mem data register, 10 = ALU result.
- imm_src  out  3  0 = I, 1 = S, 2 = B, 3 = J, 4 = U.
- alu_ctrl  out  4  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sll, 7 srl, 8 sra.
- state  out  4  current state, for debug.
- illegal  out  1  high while in TRAP.

Clock and reset are `clk` and `rst`: one clock, synchronous active-high reset.

## Operation
States and encodings: FETCH 0, DECODE 1, MEM_ADR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC_R 6, EXEC_I 7, ALU_WB 8, BRANCH 9, JAL 10, JALR 11, LUI 12, TRAP 15.

Default outputs: every enable is 0, every select is 0, alu_ctrl = add, unless a state below says otherwise.

- FETCH: adr_src 0, ir_we 1, a 00, b 10, add, res_src 10, pc_we 1 → DECODE.
- DECODE: a 01, b 01, add (ALUOut = OldPC + imm). imm_src is J for jal, otherwise B. Next state by opcode:
  - 0000011 or 0100011 → MEM_ADR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - anything else → TRAP
- MEM_ADR: a 10, b 01, add; imm_src I for loads, S for stores. funct3 ≠ 010 → TRAP; otherwise load → MEM_RD, store → MEM_WR.
- MEM_RD: adr_src 1 → MEM_WB.
- MEM_WB: res_src 01, reg_we 1 → FETCH.
- MEM_WR: adr_src 1, res_src 00, mem_we 1 → FETCH.
- EXEC_R: a 10, b 00. EXEC_I: a 10, b 01, imm_src I. Both → ALU_WB. ALU decode by funct3:
  - 000: add; sub only for R-type with funct7[5] = 1.
  - 100 xor, 110 or, 111 and, 010 slt, 001 sll.
  - 101: srl, or sra when funct7[5] = 1.
  - 011: → TRAP instead of ALU_WB.
- ALU_WB: res_src 00, reg_we 1 → FETCH.
- BRANCH: a 10, b 00, sub, res_src 00. pc_we = zero for funct3 000, ~zero for funct3 001 → FETCH. Any other funct3 → TRAP, with pc_we 0.
- JALR: a 10, b 01, imm_src I, add (ALUOut = rs1 + imm) → JAL.
- JAL: a 01, b 10, add, res_src 00, pc_we 1 (PC = ALUOut, the target) → ALU_WB, which writes OldPC + 4 to rd.
- LUI: a 11, b 01, imm_src U, add → ALU_WB.
- TRAP: illegal 1, all enables 0; holds until rst.

Register-file rules:
- rd = x0 is the register file's concern.
- rd = rs1 on jalr is safe because rs1 is consumed in the JALR state.

## Timing
Outputs are combinational from `state` and `instr`; state is registered.

Reset:
- While rst = 1, pc_we, ir_we, reg_we and mem_we are forced to 0.
- The next state is FETCH, regardless of the current state, including MEM_WR and TRAP.
- In the first cycle after reset, state = 0 and illegal = 0.

Cycles per instruction (mem_rdy always 1):
- lw 5, sw 4.
- R-type, I-type, lui, jal: 4.
- jalr 5.
- beq/bne 3.

## Configuration
MCYC_MEM_WAIT_EN:
- Defined:
  - FETCH, MEM_RD and MEM_WR hold their state until mem_rdy = 1.
  - In FETCH, ir_we and pc_we equal mem_rdy.
  - In MEM_WR, mem_we stays 1 while waiting.
- Undefined: mem_rdy is ignored and every memory access takes one cycle.

## Test plan
- Reset, then add x3,x1,x2 (0x002081b3), mem_rdy = 1 → states 0,1,6,8,0; alu_ctrl 0 in state 6; reg_we high only in state 8.
- jalr ra,x3,4 (0x004180e7) → states 0,1,11,10,8,0; pc_we high in states 0 and 10; a = 10, b = 01 in state 11; res_src 00 in state 8.
- beq (funct3 000) with zero = 1, then with zero = 0 → pc_we 1, then 0, in state 9; FETCH follows after 3 cycles; bne gives the inverse.
- With MCYC_MEM_WAIT_EN, lw with mem_rdy low for 2 cycles in MEM_RD → state 3 held for 3 cycles, then 4, then 0; ir_we stays 0 in FETCH while mem_rdy = 0.
- Instruction 0x00000000 → TRAP (15), illegal = 1, all enables 0 for 10 cycles; rst → state 0, illegal = 0.
- rst asserted during MEM_WR → mem_we 0 in that cycle; state 0 on the next cycle.
